i2c_master_tx: RTL and testbench
================================

Name: i2c_master_tx

Overview:
- Write-only I2C master for the display bus. It is the consumer of the init sequencer's reg_addr/tx_data/tx_en/tx_done handshake.
- Each transaction is: START, device address byte with W=0, control byte (reg_addr), data byte (tx_data), STOP.
- Drives SCL push-pull and SDA open-drain (sda_oe=1 pulls low). Checks slave ACK after each byte.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; must be >= 2.
- DEV_ADDR, 7'h3F: 7-bit slave address sent in the first byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- reg_addr  in  8  second byte on the bus (control byte); latched at transaction start
- tx_data  in  8  third byte on the bus; latched at transaction start
- tx_en  in  1  request level; sampled only in IDLE
- tx_done  out  1  completion strobe; high for exactly 2 clk cycles per transaction
- ack_err  out  1  high when the last transaction saw a NACK; cleared at next START
- busy  out  1  high from leaving IDLE until re-entering IDLE
- scl  out  1  SCL, push-pull
- sda_oe  out  1  1 = drive SDA low, 0 = release
- sda_in  in  1  SDA pad value, synchronised externally

Behaviour:
- Reset values: scl=1, sda_oe=0, tx_done=0, ack_err=0, busy=0, state=IDLE, tick counter=0.
- Reset mid-transaction releases the bus immediately. No STOP is generated.
- Tick generator: counter 0..CLK_DIV-1 produces a 1-cycle qtick. The counter is held at 0 in IDLE.
- Each bit lasts 4 quarters, q0..q3:
  - q0: SCL low, set SDA.
  - q1: SCL low.
  - q2: SCL high.
  - q3: SCL high, sample sda_in on the qtick.
- States and transitions:
  - IDLE: if tx_en=1, latch bytes {DEV_ADDR,0}, reg_addr, tx_data; clear ack_err; set busy; go to START.
  - START (4 quarters): q0-q1 SCL=1, SDA released; q2 sda_oe=1 with SCL=1 (START condition); q3 SCL=0. Then go to BYTE.
  - BYTE: byte index 0..2, bit counter 7..0, MSB first. sda_oe = ~bit. After bit 0, go to ACK.
  - ACK: SDA released for 4 quarters; sda_in sampled at q3.
    - Sample 0 and index < 2: index+1, return to BYTE.
    - Sample 0 and index = 2: go to STOP.
    - Sample 1 (NACK): set ack_err, go to STOP. Remaining bytes are skipped.
  - STOP (4 quarters): q0-q1 SCL=0 with sda_oe=1; q2 SCL=1; q3 sda_oe=0 with SCL=1 (STOP condition). Then go to DONE.
  - DONE: tx_done=1 for 2 clk cycles, then go to BUS_FREE. Two cycles guarantee that a consumer sampling every other cycle sees it.
  - BUS_FREE: 4*CLK_DIV cycles with SCL=1, SDA released, tx_done=0. Then go to IDLE and clear busy.
- Latency (no NACK): 116*CLK_DIV cycles from the IDLE tx_en sample to tx_done rising. That is 4 quarters of START + 27 bits*4 + 4 quarters of STOP.
- With a NACK on byte 0, tx_done rises at (4+36+4)*CLK_DIV = 44*CLK_DIV.
- tx_en held permanently high gives back-to-back transactions, separated by DONE+BUS_FREE = 2 + 4*CLK_DIV cycles. New bytes are latched on IDLE entry.
- tx_en changes outside IDLE are ignored. reg_addr/tx_data changes after latch have no effect.
- SDA changes only while SCL=0, except for the START and STOP edges.

Decomposition:
- Shared package i2c_pkg:
  - state encoding: IDLE, START, BYTE, ACK, STOP, DONE, BUS_FREE
  - quarter-phase constants Q0..Q3
  - I2C_WRITE_BIT = 0
  - TX_DONE_CYCLES = 2
  - default DEV_ADDR
- One sub-module: i2c_quarter_tick (parameter CLK_DIV). Inputs clk, rst, enable; outputs qtick, qphase[1:0].

Test Plan:
- CLK_DIV=4, DEV_ADDR=7'h3F, reg_addr=8'h00, tx_data=8'hE2, slave model ACKs every byte:
  - bus decodes bytes 7E, 00, E2 with START and STOP;
  - tx_done rises at cycle 464 after the tx_en sample and stays high 2 cycles;
  - ack_err=0.
- Slave NACKs the address byte:
  - ack_err=1, STOP issued, no further SCL pulses;
  - tx_done at 176 cycles.
- tx_en held high, consumer advances tx_data on tx_done (E2, then A2):
  - second transaction latches A2;
  - inter-transaction gap is 18 cycles of SCL=1 with SDA released.
- Assert rst during bit 3 of byte 1:
  - scl=1, sda_oe=0, busy=0, tx_done=0 within the reset cycle;
  - after release with tx_en=1, a fresh START occurs.
- Protocol checker over a full run:
  - SDA never changes while SCL=1, except the START/STOP edges;
  - SCL high and low each last 2*CLK_DIV cycles.
- CLK_DIV=2 (minimum): frame 7E/00/AF decodes correctly; tx_done at 232 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the write-only I2C master: FSM states, quarter phases,
// protocol constants and the per-quarter bus level table.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP,
    DONE,
    BUS_FREE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic       I2C_WRITE_BIT    = 1'b0;
  localparam int         TX_DONE_CYCLES   = 2;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3F;

  // Returns {scl, sda_oe} for a given state and quarter; data_bit only matters in BYTE.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] ph,
                                            input logic data_bit);
    logic [1:0] lv;
    lv = 2'b10;
    case (st)
      START: begin
        case (ph)
          Q2:      lv = 2'b11;  // SDA falls while SCL high: START condition
          Q3:      lv = 2'b01;  // pull SCL low, keep SDA low
          default: lv = 2'b10;
        endcase
      end
      BYTE:    lv = {ph[1], ~data_bit};
      ACK:     lv = {ph[1], 1'b0};
      STOP:    lv = (ph == Q3) ? 2'b10 : {ph[1], 1'b1};  // SDA rises while SCL high at q3
      default: lv = 2'b10;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period tick generator: a qtick every CLK_DIV cycles while enabled,
// with a 2-bit quarter phase that advances on each qtick. Both held at 0 when disabled.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       qtick,
  output logic [1:0] qphase
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    phase_reg;

  assign qtick  = enable && (cnt_reg == LAST);
  assign qphase = phase_reg;

  // Divider counter and quarter phase; cleared whenever the master is not using the bus clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      phase_reg <= Q0;
    end else if (!enable) begin
      cnt_reg   <= '0;
      phase_reg <= Q0;
    end else if (cnt_reg == LAST) begin
      cnt_reg   <= '0;
      phase_reg <= phase_reg + 2'd1;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, control byte, data byte, STOP.
// SCL push-pull, SDA open-drain via sda_oe, slave ACK checked after every byte.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_done,
  output logic       ack_err,
  output logic       busy,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  state_t     state_reg;
  logic [7:0] bytes_reg [3];
  logic [1:0] idx_reg;
  logic [2:0] bit_reg;
  logic [1:0] done_cnt_reg;
  logic       scl_reg;
  logic       sda_oe_reg;
  logic       tx_done_reg;
  logic       ack_err_reg;
  logic       busy_reg;

  logic       tick_en;
  logic       qtick;
  logic [1:0] qphase;
  logic [1:0] next_phase;
  logic [1:0] idx_inc;
  logic       cur_bit;
  logic       next_bit_in_byte;
  logic       first_bit_next_byte;

  assign tick_en = (state_reg == START) || (state_reg == BYTE) || (state_reg == ACK) ||
                   (state_reg == STOP)  || (state_reg == BUS_FREE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (tick_en),
    .qtick  (qtick),
    .qphase (qphase)
  );

  assign next_phase          = qphase + 2'd1;
  assign idx_inc             = idx_reg + 2'd1;
  assign cur_bit             = bytes_reg[idx_reg][bit_reg];
  assign next_bit_in_byte    = bytes_reg[idx_reg][bit_reg - 3'd1];
  assign first_bit_next_byte = bytes_reg[idx_inc][7];

  assign scl     = scl_reg;
  assign sda_oe  = sda_oe_reg;
  assign tx_done = tx_done_reg;
  assign ack_err = ack_err_reg;
  assign busy    = busy_reg;

  // Transaction FSM; bus levels are registered for the quarter being entered on each qtick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      scl_reg      <= 1'b1;
      sda_oe_reg   <= 1'b0;
      tx_done_reg  <= 1'b0;
      ack_err_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      idx_reg      <= 2'd0;
      bit_reg      <= 3'd7;
      done_cnt_reg <= 2'd0;
      for (int i = 0; i < 3; i++) bytes_reg[i] <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tx_en) begin
            bytes_reg[0] <= {DEV_ADDR, I2C_WRITE_BIT};
            bytes_reg[1] <= reg_addr;
            bytes_reg[2] <= tx_data;
            idx_reg      <= 2'd0;
            bit_reg      <= 3'd7;
            ack_err_reg  <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= START;
            {scl_reg, sda_oe_reg} <= bus_levels(START, Q0, 1'b0);
          end
        end
        START: begin
          if (qtick) begin
            if (qphase == Q3) begin
              state_reg <= BYTE;
              {scl_reg, sda_oe_reg} <= bus_levels(BYTE, Q0, cur_bit);
            end else begin
              {scl_reg, sda_oe_reg} <= bus_levels(START, next_phase, 1'b0);
            end
          end
        end
        BYTE: begin
          if (qtick) begin
            if (qphase != Q3) begin
              {scl_reg, sda_oe_reg} <= bus_levels(BYTE, next_phase, cur_bit);
            end else if (bit_reg == 3'd0) begin
              state_reg <= ACK;
              {scl_reg, sda_oe_reg} <= bus_levels(ACK, Q0, 1'b0);
            end else begin
              bit_reg <= bit_reg - 3'd1;
              {scl_reg, sda_oe_reg} <= bus_levels(BYTE, Q0, next_bit_in_byte);
            end
          end
        end
        ACK: begin
          if (qtick) begin
            if (qphase != Q3) begin
              {scl_reg, sda_oe_reg} <= bus_levels(ACK, next_phase, 1'b0);
            end else if (sda_in || (idx_reg == 2'd2)) begin
              // NACK aborts the remaining bytes; a clean ACK on the last byte also ends here
              if (sda_in) ack_err_reg <= 1'b1;
              state_reg <= STOP;
              {scl_reg, sda_oe_reg} <= bus_levels(STOP, Q0, 1'b0);
            end else begin
              idx_reg   <= idx_inc;
              bit_reg   <= 3'd7;
              state_reg <= BYTE;
              {scl_reg, sda_oe_reg} <= bus_levels(BYTE, Q0, first_bit_next_byte);
            end
          end
        end
        STOP: begin
          if (qtick) begin
            if (qphase == Q3) begin
              state_reg    <= DONE;
              tx_done_reg  <= 1'b1;
              done_cnt_reg <= 2'd0;
              {scl_reg, sda_oe_reg} <= bus_levels(DONE, Q0, 1'b0);
            end else begin
              {scl_reg, sda_oe_reg} <= bus_levels(STOP, next_phase, 1'b0);
            end
          end
        end
        DONE: begin
          // tx_done is stretched so a consumer sampling every other cycle still sees it
          if (done_cnt_reg == 2'(TX_DONE_CYCLES - 1)) begin
            tx_done_reg <= 1'b0;
            state_reg   <= BUS_FREE;
          end else begin
            done_cnt_reg <= done_cnt_reg + 2'd1;
          end
        end
        BUS_FREE: begin
          if (qtick && (qphase == Q3)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Scoreboard bench for i2c_master_tx: a bus decoder with slave model and a
// tx_done monitor pop expected frames/completions pushed by the stimulus.
`timescale 1ns/1ps
module tb_i2c_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_en  = 1'b0;
  logic       tx_en2 = 1'b0;
  logic       sel    = 1'b0;   // 0: CLK_DIV=4 instance, 1: CLK_DIV=2 instance
  logic       pull   = 1'b0;   // slave pulling SDA low

  logic tx_done1, ack_err1, busy1, scl1, sda_oe1;
  logic tx_done2, ack_err2, busy2, scl2, sda_oe2;
  logic scl_m, oe_m, done_m, busy_m, aerr_m, sda_line;

  assign scl_m    = sel ? scl2     : scl1;
  assign oe_m     = sel ? sda_oe2  : sda_oe1;
  assign done_m   = sel ? tx_done2 : tx_done1;
  assign busy_m   = sel ? busy2    : busy1;
  assign aerr_m   = sel ? ack_err2 : ack_err1;
  assign sda_line = ~(oe_m | pull);

  always #5 clk = ~clk;

  i2c_master_tx #(.CLK_DIV(4), .DEV_ADDR(7'h3F)) dut4 (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .tx_data(tx_data), .tx_en(tx_en),
    .tx_done(tx_done1), .ack_err(ack_err1), .busy(busy1), .scl(scl1), .sda_oe(sda_oe1),
    .sda_in(sda_line)
  );

  i2c_master_tx #(.CLK_DIV(2), .DEV_ADDR(7'h3F)) dut2 (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .tx_data(tx_data), .tx_en(tx_en2),
    .tx_done(tx_done2), .ack_err(ack_err2), .busy(busy2), .scl(scl2), .sda_oe(sda_oe2),
    .sda_in(sda_line)
  );

  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [2:0]  acks;
  } frame_t;

  typedef struct {
    int   lat;
    logic aerr;
  } done_t;

  frame_t frame_q[$];
  done_t  done_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nack_byte = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus decoder + slave ACK model ----------------
  logic        prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
  int          bitcnt = 0, rises = 0, falls = 0, t_edge = 0, nb = 0, cd = 4;
  logic [7:0]  shreg = 8'h00;
  logic [23:0] dbytes = 24'h0;
  logic [2:0]  dacks = 3'b0;
  frame_t      fexp;

  initial forever begin
    @(negedge clk);
    cd = sel ? 2 : 4;
    if (rst) begin
      in_frame = 1'b0;
      pull     = 1'b0;
      t_edge   = cyc;
    end else begin
      if (scl_m && prev_scl && (sda_line !== prev_sda)) begin
        if (!sda_line) begin
          in_frame = 1'b1; bitcnt = 0; rises = 0; falls = 0; nb = 0;
          dbytes = 24'h0; dacks = 3'b0;
        end else begin
          if (frame_q.size() == 0) begin
            check("frame_unexpected", frame_q.size(), 1);
          end else begin
            fexp = frame_q.pop_front();
            $display("txn: bytes=%h acks=%b n=%0d rises=%0d", dbytes, dacks, nb, rises);
            check("frame_nbytes", nb, fexp.n);
            check("frame_bytes", dbytes, fexp.bytes);
            check("frame_acks", dacks, fexp.acks);
            check("frame_scl_pulses", rises, 9 * fexp.n + 1);
          end
          in_frame = 1'b0;
        end
      end
      if (scl_m && !prev_scl) begin
        if (in_frame) begin
          check("scl_low_len", cyc - t_edge, (rises == 0) ? 3 * cd : 2 * cd);
          rises++;
          if (bitcnt < 8) begin
            shreg = {shreg[6:0], sda_line};
            bitcnt++;
          end else begin
            dbytes = {dbytes[15:0], shreg};
            dacks  = {dacks[1:0], sda_line};
            nb++;
            bitcnt = 0;
          end
        end
        t_edge = cyc;
      end
      if (!scl_m && prev_scl) begin
        if (!in_frame) begin
          check("scl_fall_outside_frame", scl_m, 1);
        end else begin
          if (falls > 0) check("scl_high_len", cyc - t_edge, 2 * cd);
          falls++;
          pull = (bitcnt == 8) && (nb != nack_byte);
        end
        t_edge = cyc;
      end
    end
    prev_scl = scl_m;
    prev_sda = sda_line;
  end

  // ---------------- tx_done / busy monitor ----------------
  logic  pb = 1'b0, pd = 1'b0, in_gap = 1'b0;
  int    t_busy = 0, t_done = 0, gap_bad = 0;
  done_t dexp;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_gap = 1'b0;
      pb = 1'b0;
      pd = 1'b0;
    end else begin
      if (busy_m && !pb) t_busy = cyc;
      if (done_m && !pd) begin
        t_done = cyc; in_gap = 1'b1; gap_bad = 0;
        if (done_q.size() == 0) begin
          check("done_unexpected", done_q.size(), 1);
        end else begin
          dexp = done_q.pop_front();
          check("done_latency", cyc - t_busy, dexp.lat);
          check("ack_err", aerr_m, dexp.aerr);
        end
      end
      if (!done_m && pd) check("done_width", cyc - t_done, 2);
      if (in_gap && !(scl_m && !oe_m)) gap_bad++;
      if (!busy_m && pb && in_gap) begin
        check("gap_len", cyc - t_done, sel ? 10 : 18);
        check("gap_bus_idle", gap_bad, 0);
        in_gap = 1'b0;
      end
      pb = busy_m;
      pd = done_m;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    while ((busy_m !== lvl) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (busy_m !== lvl) check("wait_busy_timeout", busy_m, lvl);
  endtask

  task automatic wait_done(input logic lvl, input int budget);
    int n = 0;
    while ((done_m !== lvl) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (done_m !== lvl) check("wait_done_timeout", done_m, lvl);
  endtask

  task automatic push(input int n, input logic [23:0] b, input logic [2:0] a,
                      input int lat, input logic aerr);
    frame_t f;
    done_t  d;
    f.n = n; f.bytes = b; f.acks = a;
    d.lat = lat; d.aerr = aerr;
    frame_q.push_back(f);
    done_q.push_back(d);
  endtask

  task automatic run_txn(input logic [7:0] ra, input logic [7:0] td, input int nack);
    reg_addr  = ra;
    tx_data   = td;
    nack_byte = nack;
    if (sel) tx_en2 = 1'b1; else tx_en = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 10);
    tx_en  = 1'b0;
    tx_en2 = 1'b0;
    reg_addr = 8'hFF;   // changes after latch must not reach the bus
    tx_data  = 8'hFF;
    wait_busy(1'b0, 2000);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_scl", scl1, 1);
    check("rst_sda_oe", sda_oe1, 0);
    check("rst_tx_done", tx_done1, 0);
    check("rst_ack_err", ack_err1, 0);
    check("rst_busy", busy1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full write, all bytes ACKed
    push(3, 24'h7E00E2, 3'b000, 464, 1'b0);
    run_txn(8'h00, 8'hE2, -1);

    // NACK on the address byte: STOP right after, no further bytes
    push(1, 24'h00007E, 3'b001, 176, 1'b1);
    run_txn(8'h00, 8'hE2, 0);

    // NACK on the last byte
    push(3, 24'h7E3C5A, 3'b001, 464, 1'b1);
    run_txn(8'h3C, 8'h5A, 2);

    // back-to-back with tx_en held high; consumer advances tx_data on tx_done
    push(3, 24'h7E00E2, 3'b000, 464, 1'b0);
    push(3, 24'h7E00A2, 3'b000, 464, 1'b0);
    nack_byte = -1;
    reg_addr  = 8'h00;
    tx_data   = 8'hE2;
    tx_en     = 1'b1;
    @(negedge clk);
    wait_done(1'b1, 1000);
    tx_data = 8'hA2;
    wait_done(1'b0, 10);
    wait_done(1'b1, 1000);
    tx_en = 1'b0;
    wait_busy(1'b0, 100);
    @(negedge clk);

    // reset during bit 3 of byte 1
    reg_addr = 8'h5A;
    tx_data  = 8'h11;
    tx_en    = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 10);
    tx_en = 1'b0;
    repeat (230) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl", scl1, 1);
    check("midrst_sda_oe", sda_oe1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_tx_done", tx_done1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(3, 24'h7E5AC3, 3'b000, 464, 1'b0);
    run_txn(8'h5A, 8'hC3, -1);

    // minimum divider instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    push(3, 24'h7E00AF, 3'b000, 232, 1'b0);
    run_txn(8'h00, 8'hAF, -1);

    repeat (10) @(negedge clk);
    check("frames_left", frame_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
